bf_img_port: RTL and testbench

- DUT-side master of the bilateral-filter image-memory interface.
- Read side: raster-scans `in_addr` over the whole frame and captures `in_data` (one-cycle read latency). Delivers each pixel with x/y coordinates to the filter core on a valid/ready stream.
- Write side: accepts filtered results from the core, drives `out_valid`/`out_addr`/`out_data`, and asserts `finish` once every pixel of the frame is written.
- Sits between the top-level pins and the filter datapath.

---
 rtl/bf_pkg.sv | 19 +
 rtl/bf_skid_fifo.sv | 74 +++++++
 rtl/bf_img_port.sv | 150 +++++++++++++++
 tb/tb_bf_img_port.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/bf_pkg.sv
// Shared constants and FSM encoding for the bilateral-filter image port.
package bf_pkg;

  localparam int IMG_W = 256;
  localparam int IMG_H = 256;
  localparam int AW    = 16;
  localparam int DW    = 8;
  localparam int XW    = $clog2(IMG_W);
  localparam int YW    = $clog2(IMG_H);
  localparam int NPIX  = IMG_W * IMG_H;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/bf_skid_fifo.sv
// Small synchronous FIFO holding {addr, data} pairs captured from image memory.
// Push into a full FIFO is accepted only together with a pop; flush empties it.
module bf_skid_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [W-1:0]  push_dat_i,
  input  logic          pop_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o,
  output logic [W-1:0]  head_dat_o
);
  localparam int PW = $clog2(DEPTH);
  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [W-1:0] mem_q [DEPTH];
  ptr_t rd_q, rd_d, wr_q, wr_d;
  cnt_t count_q, count_d;
  logic do_push, do_pop;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign full_o     = (count_q == cnt_t'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign head_dat_o = mem_q[rd_q];
  assign do_pop     = pop_i && !empty_o;
  assign do_push    = push_i && (!full_o || do_pop);

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (flush_i) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (do_pop)  rd_d = ptr_inc(rd_q);
      if (do_push) wr_d = ptr_inc(wr_q);
      count_d = count_q + cnt_t'(do_push) - cnt_t'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push && !flush_i) begin
      mem_q[wr_q] <= push_dat_i;
    end
  end

endmodule

// File: rtl/bf_img_port.sv
// Image-memory master: raster-reads the frame into a valid/ready pixel stream and
// writes filtered results back in raster order, raising finish when the frame is done.
module bf_img_port #(
  parameter int IMG_W      = bf_pkg::IMG_W,
  parameter int IMG_H      = bf_pkg::IMG_H,
  parameter int AW         = bf_pkg::AW,
  parameter int DW         = bf_pkg::DW,
  parameter int SKID_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic [AW-1:0]              in_addr,
  input  logic [DW-1:0]              in_data,
  output logic                       pix_valid,
  input  logic                       pix_ready,
  output logic [DW-1:0]              pix_data,
  output logic [$clog2(IMG_W)-1:0]   pix_x,
  output logic [$clog2(IMG_H)-1:0]   pix_y,
  input  logic                       res_valid,
  input  logic [DW-1:0]              res_data,
  output logic                       out_valid,
  output logic [AW-1:0]              out_addr,
  output logic [DW-1:0]              out_data,
  output logic                       finish
);
  import bf_pkg::*;

  localparam int XW = $clog2(IMG_W);
  localparam int CW = $clog2(SKID_DEPTH + 1);
  localparam int FW = AW + DW;

  typedef logic [AW:0]   cnt_t;
  typedef logic [AW-1:0] addr_t;
  typedef logic [CW:0]   occ_t;

  localparam cnt_t NPIX_C = cnt_t'(IMG_W * IMG_H);
  localparam cnt_t LAST_C = NPIX_C - cnt_t'(1);

  state_t  state_q, state_d;
  cnt_t    addr_q, addr_d, wr_cnt_q, wr_cnt_d;
  logic    inflight_q, inflight_d;
  logic    out_valid_q, out_valid_d;
  addr_t   out_addr_q, out_addr_d;
  logic [DW-1:0] out_data_q, out_data_d;

  logic          iss, pop, clear, wr_en, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [FW-1:0] head;
  addr_t         cap_addr, head_addr;
  occ_t          load;

  // One-cycle memory latency: the word arriving now belongs to the previous address.
  assign cap_addr  = addr_q[AW-1:0] - addr_t'(1);
  assign pop       = pix_valid && pix_ready;
  assign load      = occ_t'(fifo_count) + occ_t'(inflight_q) - occ_t'(pop);
  assign iss       = in_valid && (state_q == IDLE || state_q == FETCH) &&
                     (addr_q != NPIX_C) && (load < occ_t'(SKID_DEPTH));
  assign clear     = (state_d == IDLE);
  assign wr_en     = res_valid && (state_q == FETCH || state_q == DRAIN) &&
                     (wr_cnt_q != NPIX_C);

  bf_skid_fifo #(
    .DEPTH (SKID_DEPTH),
    .W     (FW)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (clear),
    .push_i     (inflight_q),
    .push_dat_i ({cap_addr, in_data}),
    .pop_i      (pop),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count),
    .head_dat_o (head)
  );

  assign head_addr = head[FW-1:DW];
  assign pix_valid = !fifo_empty;
  assign pix_data  = pix_valid ? head[DW-1:0] : '0;
  assign pix_x     = pix_valid ? head_addr[XW-1:0] : '0;
  assign pix_y     = pix_valid ? head_addr[AW-1:XW] : '0;
  // After the final issue the counter sits at NPIX; keep showing the last address.
  assign in_addr   = addr_q[AW] ? '1 : addr_q[AW-1:0];
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign finish    = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = FETCH;
      FETCH:   if (!in_valid) state_d = IDLE;
               else if (iss && addr_q == LAST_C) state_d = DRAIN;
      DRAIN:   if (!in_valid) state_d = IDLE;
               else if (wr_cnt_q == NPIX_C) state_d = DONE;
      DONE:    if (!in_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d      = addr_q;
    inflight_d  = iss;
    wr_cnt_d    = wr_cnt_q;
    out_valid_d = wr_en;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    if (iss) addr_d = addr_q + cnt_t'(1);
    if (wr_en) begin
      out_addr_d = wr_cnt_q[AW-1:0];
      out_data_d = res_data;
      wr_cnt_d   = wr_cnt_q + cnt_t'(1);
    end
    if (clear) begin
      addr_d      = '0;
      inflight_d  = 1'b0;
      wr_cnt_d    = '0;
      out_valid_d = 1'b0;
      out_addr_d  = '0;
      out_data_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      inflight_q  <= 1'b0;
      wr_cnt_q    <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      inflight_q  <= inflight_d;
      wr_cnt_q    <= wr_cnt_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
    end
  end

  // Issue throttling guarantees a capture never lands on a full buffer without a pop.
  assert property (@(posedge clk) disable iff (!rst) (inflight_q && fifo_full) |-> pop);

endmodule

// File: tb/tb_bf_img_port.sv
// Directed bench for bf_img_port on a 16x8 frame; memory returns mem[a] = a.
module tb_bf_img_port;
  localparam int W    = 16;
  localparam int H    = 8;
  localparam int AW   = 7;
  localparam int DW   = 8;
  localparam int NPIX = W * H;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data = '0;
  logic          pix_valid;
  logic          pix_ready;
  logic [DW-1:0] pix_data;
  logic [3:0]    pix_x;
  logic [2:0]    pix_y;
  logic          res_valid;
  logic [DW-1:0] res_data;
  logic          out_valid;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          finish;

  int n_checks = 0;
  int n_err    = 0;

  bf_img_port #(
    .IMG_W(W), .IMG_H(H), .AW(AW), .DW(DW), .SKID_DEPTH(2)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_x(pix_x), .pix_y(pix_y), .res_valid(res_valid), .res_data(res_data),
    .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data), .finish(finish)
  );

  always #5 clk = ~clk;

  always @(posedge clk) in_data <= {1'b0, in_addr};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int got, stall, nsent, exp_addr, last_c;
    logic prev_rv;
    logic [DW-1:0] prev_d;

    rst = 1'b0; in_valid = 1'b0; pix_ready = 1'b0; res_valid = 1'b0; res_data = '0;
    @(negedge clk);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_in_addr", in_addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_finish", finish, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // full-rate streaming
    pix_ready = 1'b1;
    in_valid  = 1'b1;
    for (int c = 1; c <= NPIX + 2; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("lat_c1_valid", pix_valid, 0);
        chk("lat_c1_addr", in_addr, 1);
      end else if (c <= NPIX + 1) begin
        chk("st_valid", pix_valid, 1);
        chk("st_data", pix_data, c - 2);
        chk("st_xy", {pix_y, pix_x}, c - 2);
      end else begin
        chk("st_end_valid", pix_valid, 0);
        chk("st_addr_hold", in_addr, NPIX - 1);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("drain_abort_addr", in_addr, 0);
    chk("drain_abort_valid", pix_valid, 0);
    @(negedge clk);

    // backpressure at pixel 30, then writes every third cycle
    in_valid = 1'b1;
    got = 0; stall = 0;
    for (int c = 0; c < 1000 && got < NPIX; c++) begin
      @(negedge clk);
      if (pix_valid && got == 30 && stall < 10) begin
        pix_ready = 1'b0;
        stall++;
        chk("bp_hold_data", pix_data, 30);
        chk("bp_addr_stall", in_addr, 32);
      end else begin
        pix_ready = 1'b1;
      end
      if (pix_valid && pix_ready) begin
        chk("bp_data", pix_data, got);
        chk("bp_xy", {pix_y, pix_x}, got);
        got++;
      end
    end
    chk("bp_total", got, NPIX);
    chk("bp_stall_cycles", stall, 10);
    @(negedge clk);
    chk("bp_no_dup", pix_valid, 0);

    nsent = 0; exp_addr = 0; prev_rv = 1'b0; prev_d = '0; last_c = -10;
    for (int c = 0; c < 3 * NPIX + 6; c++) begin
      @(negedge clk);
      if (prev_rv) begin
        chk("wr_valid", out_valid, 1);
        chk("wr_addr", out_addr, exp_addr);
        chk("wr_data", out_data, prev_d);
        exp_addr++;
        if (exp_addr == NPIX) begin
          chk("fin_not_yet", finish, 0);
          last_c = c;
        end
      end else begin
        chk("wr_idle", out_valid, 0);
      end
      if (c == last_c + 1) chk("fin_rise", finish, 1);
      prev_rv   = (c % 3 == 0) && (nsent < NPIX);
      res_valid = prev_rv;
      res_data  = 8'(c * 7 + 3);
      prev_d    = res_data;
      if (prev_rv) nsent++;
    end
    chk("wr_count", exp_addr, NPIX);

    res_valid = 1'b1; res_data = 8'hEE;
    @(negedge clk);
    @(negedge clk);
    chk("post_fin_drop", out_valid, 0);
    chk("post_fin_finish", finish, 1);
    res_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("fin_hold", finish, 1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("fin_clear", finish, 0);
    chk("fin_out_valid", out_valid, 0);
    chk("fin_out_addr", out_addr, 0);
    chk("fin_in_addr", in_addr, 0);

    // abort at pixel 20, then restart
    in_valid = 1'b1; pix_ready = 1'b1; got = 0;
    for (int c = 0; c < 100 && in_valid; c++) begin
      @(negedge clk);
      if (pix_valid) begin
        chk("ab_data", pix_data, got);
        got++;
        if (got == 21) in_valid = 1'b0;
      end
    end
    chk("ab_reached", got, 21);
    @(negedge clk);
    chk("ab_flush_valid", pix_valid, 0);
    chk("ab_addr", in_addr, 0);
    @(negedge clk);
    chk("ab_idle_valid", pix_valid, 0);
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("rs_valid", pix_valid, 1);
    chk("rs_data", pix_data, 0);
    chk("rs_xy", {pix_y, pix_x}, 0);

    // asynchronous reset in the middle of a frame
    repeat (10) @(negedge clk);
    chk("pre_rst_addr", in_addr, 12);
    #2 rst = 1'b0;
    #1;
    chk("arst_pix_valid", pix_valid, 0);
    chk("arst_pix_data", pix_data, 0);
    chk("arst_in_addr", in_addr, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_finish", finish, 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_valid", pix_valid, 0);
    chk("post_rst_addr", in_addr, 0);
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_first", pix_valid, 1);
    chk("post_rst_data", pix_data, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
